// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 VGA timing generator that gates framebuffer pixels to the DAC.
// Define VGA_CTRL_SYNC_DELAY_EN to delay valid/sync/frame_start one clock for a synchronous-read framebuffer.
module vga_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic [15:0] frame_cnt_r;
  logic        h_wrap_s;
  logic        v_wrap_s;
  logic        active_s;
  logic        hsync_raw_s;
  logic        vsync_raw_s;
  logic        fs_raw_s;
  logic        valid_s;
  logic [11:0] rgb_s;

  // Raw timing terms and framebuffer address, all decoded from the counters.
  always_comb begin
    h_wrap_s    = (h_cnt_r == H_LAST);
    v_wrap_s    = (v_cnt_r == V_LAST);
    active_s    = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    hsync_raw_s = !((h_cnt_r >= H_SS) && (h_cnt_r < H_SE));
    vsync_raw_s = !((v_cnt_r >= V_SS) && (v_cnt_r < V_SE));
    fs_raw_s    = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    if (active_s) begin
      h_addr = h_cnt_r;
      v_addr = v_cnt_r;
    end else begin
      h_addr = 10'd0;
      v_addr = 10'd0;
    end
  end

  // Pixel/line counters; the frame count only advances when a whole frame completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt_r     <= 10'd0;
      v_cnt_r     <= 10'd0;
      frame_cnt_r <= 16'd0;
    end else if (h_wrap_s) begin
      h_cnt_r <= 10'd0;
      if (v_wrap_s) begin
        v_cnt_r     <= 10'd0;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

`ifdef VGA_CTRL_SYNC_DELAY_EN
  logic valid_r;
  logic hsync_r;
  logic vsync_r;
  logic fs_r;

  // One-clock alignment stage matching the block-RAM read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      fs_r    <= 1'b0;
    end else begin
      valid_r <= active_s;
      hsync_r <= hsync_raw_s;
      vsync_r <= vsync_raw_s;
      fs_r    <= fs_raw_s;
    end
  end

  assign valid_s     = valid_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign frame_start = fs_r;
`else
  // Counters sit at (0,0) during reset, so the raw terms must be masked by reset itself.
  assign valid_s     = active_s & ~reset;
  assign hsync       = hsync_raw_s | reset;
  assign vsync       = vsync_raw_s | reset;
  assign frame_start = fs_raw_s & ~reset;
`endif

  // Blank the DAC outside the visible window.
  always_comb begin
    if (valid_s) begin
      rgb_s = vga_data;
    end else begin
      rgb_s = 12'h000;
    end
  end

  assign valid               = valid_s;
  assign {vga_r, vga_g, vga_b} = rgb_s;
  assign frame_cnt           = frame_cnt_r;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: scoreboard bench for vga_ctrl; a default-timing instance covers line timing,
// a small-timing instance covers whole frames, reset and frame counter wrap.
module tb_vga_ctrl;

`ifdef VGA_CTRL_SYNC_DELAY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int SH_A = 16, SH_FP = 2, SH_S = 3, SH_BP = 4;
  localparam int SV_A = 8,  SV_FP = 2, SV_S = 2, SV_BP = 3;
  localparam int S_FT = 375;

  typedef struct {
    int          k;
    logic        valid, hs, vs, fs;
    logic [9:0]  ha, va;
    logic [11:0] rgb;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        const_mode = 1'b0;
  logic [15:0] base_s = 16'h0000;
  int          errors = 0;
  int          checks = 0;

  logic [9:0]  b_ha, b_va, s_ha, s_va;
  logic        b_hs, b_vs, b_valid, b_fs, s_hs, s_vs, s_valid, s_fs;
  logic [3:0]  b_r, b_g, b_b, s_r, s_g, s_b;
  logic [15:0] b_fc, s_fc;
  logic [11:0] fb_b, fb_s;

  exp_t q_b[$];
  exp_t q_s[$];
  int   k_b = 0;
  int   k_s = 0;

  always #5 clk = ~clk;

  vga_ctrl dut_b (
    .clock(clk), .reset(rst), .vga_data(fb_b), .h_addr(b_ha), .v_addr(b_va),
    .hsync(b_hs), .vsync(b_vs), .valid(b_valid), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_ctrl #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
  ) dut_s (
    .clock(clk), .reset(rst), .vga_data(fb_s), .h_addr(s_ha), .v_addr(s_va),
    .hsync(s_hs), .vsync(s_vs), .valid(s_valid), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  function automatic logic [11:0] pat(int x, int y);
    return 12'(x * 37 + y * 101 + 5);
  endfunction

  // Framebuffer model: asynchronous read, or registered read when the delay stage is built.
`ifdef VGA_CTRL_SYNC_DELAY_EN
  always @(posedge clk) begin
    fb_b <= const_mode ? 12'hFFF : pat(int'(b_ha), int'(b_va));
    fb_s <= const_mode ? 12'hFFF : pat(int'(s_ha), int'(s_va));
  end
`else
  assign fb_b = const_mode ? 12'hFFF : pat(int'(b_ha), int'(b_va));
  assign fb_s = const_mode ? 12'hFFF : pat(int'(s_ha), int'(s_va));
`endif

  // Expected outputs for cycle k after reset release, derived from k by modulo arithmetic.
  function automatic exp_t model(int k, int ha, int hfp, int hsy, int hbp, int va, int vfp,
                                 int vsy, int vbp, logic [15:0] base, logic cm);
    exp_t e;
    int ht, vt, hc, vc, hp, vp;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    hc = k % ht;
    vc = (k / ht) % vt;
    e.k  = k;
    e.ha = (hc < ha && vc < va) ? 10'(hc) : 10'd0;
    e.va = (hc < ha && vc < va) ? 10'(vc) : 10'd0;
    e.fc = base + 16'(k / (ht * vt));
    if (k < LAT) begin
      e.valid = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.rgb = 12'h000;
    end else begin
      hp = (k - LAT) % ht;
      vp = ((k - LAT) / ht) % vt;
      e.valid = (hp < ha) && (vp < va);
      e.hs    = !(hp >= ha + hfp && hp < ha + hfp + hsy);
      e.vs    = !(vp >= va + vfp && vp < va + vfp + vsy);
      e.fs    = (hp == 0) && (vp == 0);
      e.rgb   = e.valid ? (cm ? 12'hFFF : pat(hp, vp)) : 12'h000;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input logic valid, input logic hs,
                     input logic vs, input logic fs, input logic [9:0] ha, input logic [9:0] va,
                     input logic [11:0] rgb, input logic [15:0] fc);
    chk($sformatf("%s valid k=%0d", who, e.k), 32'(valid), 32'(e.valid));
    chk($sformatf("%s hsync k=%0d", who, e.k), 32'(hs), 32'(e.hs));
    chk($sformatf("%s vsync k=%0d", who, e.k), 32'(vs), 32'(e.vs));
    chk($sformatf("%s frame_start k=%0d", who, e.k), 32'(fs), 32'(e.fs));
    chk($sformatf("%s h_addr k=%0d", who, e.k), 32'(ha), 32'(e.ha));
    chk($sformatf("%s v_addr k=%0d", who, e.k), 32'(va), 32'(e.va));
    chk($sformatf("%s rgb k=%0d", who, e.k), 32'(rgb), 32'(e.rgb));
    chk($sformatf("%s frame_cnt k=%0d", who, e.k), 32'(fc), 32'(e.fc));
  endtask

  // Expectation producers: one entry per clock while out of reset.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      k_b = 0;
      k_s = 0;
    end else begin
      q_b.push_back(model(k_b, 640, 16, 96, 48, 480, 10, 2, 33, 16'h0000, const_mode));
      q_s.push_back(model(k_s, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, base_s, const_mode));
      k_b++;
      k_s++;
    end
  end

  // Default-timing monitor: full compare plus line-0 edge positions.
  int   b_v0 = -1, b_ha0 = -1, b_vfall = -1, b_hfall = -1, b_hrise = -1;
  logic b_pv = 1'b0, b_phs = 1'b1;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        b_v0 = -1; b_ha0 = -1; b_vfall = -1; b_hfall = -1; b_hrise = -1;
        b_pv = 1'b0; b_phs = 1'b1;
      end else if (q_b.size() == 0) begin
        chk("big scoreboard entry present", 32'd0, 32'd1);
      end else begin
        e = q_b.pop_front();
        cmp("big", e, b_valid, b_hs, b_vs, b_fs, b_ha, b_va, {b_r, b_g, b_b}, b_fc);
        if (e.k == 0) begin b_v0 = int'(b_valid); b_ha0 = int'(b_ha); end
        if (b_vfall < 0 && b_pv && !b_valid) b_vfall = e.k;
        if (b_hfall < 0 && b_phs && !b_hs) b_hfall = e.k;
        if (b_hfall >= 0 && b_hrise < 0 && !b_phs && b_hs) b_hrise = e.k;
        b_pv = b_valid;
        b_phs = b_hs;
      end
    end
  end

  // Small-timing monitor: full compare plus per-frame statistics.
  int   w_valid = 0, w_hs = 0, w_vs = 0, fs_first = -1, fs_total = 0, wrap_seen = 0;
  logic s_phs = 1'b1;
  logic [15:0] s_pfc = 16'h0000;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        w_valid = 0; w_hs = 0; w_vs = 0; fs_first = -1; wrap_seen = 0;
        s_phs = 1'b1; s_pfc = 16'h0000;
      end else if (q_s.size() == 0) begin
        chk("small scoreboard entry present", 32'd0, 32'd1);
      end else begin
        e = q_s.pop_front();
        cmp("small", e, s_valid, s_hs, s_vs, s_fs, s_ha, s_va, {s_r, s_g, s_b}, s_fc);
        if (e.k >= LAT && e.k < LAT + S_FT) begin
          if (s_valid) w_valid++;
          if (!s_vs) w_vs++;
          if (s_phs && !s_hs) w_hs++;
        end
        if (s_fs) begin
          fs_total++;
          if (fs_first < 0) fs_first = e.k;
        end
        if (s_pfc == 16'hFFFF && s_fc == 16'h0000) wrap_seen++;
        s_phs = s_hs;
        s_pfc = s_fc;
      end
    end
  end

  task automatic chk_reset_all(input string tag);
    chk({tag, " big valid"}, 32'(b_valid), 32'd0);
    chk({tag, " big hsync"}, 32'(b_hs), 32'd1);
    chk({tag, " big vsync"}, 32'(b_vs), 32'd1);
    chk({tag, " big frame_start"}, 32'(b_fs), 32'd0);
    chk({tag, " big rgb"}, 32'({b_r, b_g, b_b}), 32'd0);
    chk({tag, " big frame_cnt"}, 32'(b_fc), 32'd0);
    chk({tag, " small valid"}, 32'(s_valid), 32'd0);
    chk({tag, " small hsync"}, 32'(s_hs), 32'd1);
    chk({tag, " small vsync"}, 32'(s_vs), 32'd1);
    chk({tag, " small frame_start"}, 32'(s_fs), 32'd0);
    chk({tag, " small rgb"}, 32'({s_r, s_g, s_b}), 32'd0);
    chk({tag, " small frame_cnt"}, 32'(s_fc), 32'd0);
    chk({tag, " small h_addr"}, 32'(s_ha), 32'd0);
    chk({tag, " small v_addr"}, 32'(s_va), 32'd0);
  endtask

  initial begin
    int guard;
    int fs_before;
    #2;
    chk_reset_all("reset before clock");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_all("reset with clock");
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Phase 1: two lines of default timing, almost five small frames.
    repeat (1800) @(posedge clk);
    @(negedge clk);
    #2;
    chk("big valid at cycle 0", 32'(b_v0), (LAT == 0) ? 32'd1 : 32'd0);
    chk("big h_addr at cycle 0", 32'(b_ha0), 32'd0);
    chk("big valid fall cycle", 32'(b_vfall), 32'(640 + LAT));
    chk("big hsync fall cycle", 32'(b_hfall), 32'(656 + LAT));
    chk("big hsync rise cycle", 32'(b_hrise), 32'(752 + LAT));
    chk("small hsync pulses per frame", 32'(w_hs), 32'd15);
    chk("small valid pixels per frame", 32'(w_valid), 32'd128);
    chk("small vsync low clocks", 32'(w_vs), 32'd50);
    chk("small first frame_start cycle", 32'(fs_first), 32'(LAT));

    // Phase 2: asynchronous reset mid-frame at h=10, v=5, then constant white data.
    guard = 0;
    do begin
      @(negedge clk);
      #2;
      guard++;
    end while (((k_s - 1) % S_FT) != 5 * 25 + 10 && guard < 500);
    chk("mid-frame trigger reached", (guard < 500) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_all("async reset");
    q_b.delete();
    q_s.delete();
    const_mode = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (S_FT + 50) @(posedge clk);
    @(negedge clk);
    #2;
    chk("white valid pixels per frame", 32'(w_valid), 32'd128);
    chk("white hsync pulses per frame", 32'(w_hs), 32'd15);
    chk("post-reset frame_start cycle", 32'(fs_first), 32'(LAT));

    // Phase 3: frame counter preset near wrap, three frame boundaries.
    rst = 1'b1;
    const_mode = 1'b0;
    base_s = 16'h0000;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    #2;
    force dut_s.frame_cnt_r = 16'hFFFE;
    base_s = 16'hFFFE;
    #1;
    release dut_s.frame_cnt_r;
    fs_before = fs_total;
    repeat (1060) @(posedge clk);
    @(negedge clk);
    #2;
    chk("frame_start pulses across wrap", 32'(fs_total - fs_before), 32'd3);
    chk("frame_cnt FFFF to 0000 seen", 32'(wrap_seen), 32'd1);
    chk("frame_cnt after wrap", 32'(s_fc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch, in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical front porch, sync and back porch, in lines.
REQ-005 SHALL have port clock, input, 1 bit: pixel clock (25 MHz). It is the only clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port vga_data, input, 12 bits: {r,g,b} 4b each, returned by the framebuffer for the address presented.
REQ-008 SHALL have ports h_addr and v_addr, output, 10 bits each: pixel address presented to the framebuffer.
REQ-009 SHALL have ports hsync and vsync, output, 1 bit each: active-low sync.
REQ-010 SHALL have port valid, output, 1 bit: pixel on vga_r/g/b is in the visible area.
REQ-011 SHALL have ports vga_r, vga_g and vga_b, output, 4 bits each: pixel colour to the DAC.
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the first visible pixel of each frame.
REQ-013 SHALL have port frame_cnt, output, 16 bits: count of frames completed, wrapping.

Function
REQ-014 SHALL keep h_cnt in 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); h_cnt SHALL increment every clock and wrap to 0.
REQ-015 SHALL keep v_cnt in 0..V_TOTAL-1, where V_TOTAL = 525; v_cnt SHALL increment only on the cycle h_cnt wraps, and SHALL wrap to 0 on the cycle where h_cnt wraps and v_cnt = V_TOTAL-1.
REQ-016 SHALL assert the raw active term when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-017 SHALL drive h_addr = h_cnt and v_addr = v_cnt while active, and 0 otherwise, combinationally from the counters.
REQ-018 SHALL drive raw hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-019 SHALL drive raw vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-020 SHALL assert raw frame_start iff h_cnt = 0 and v_cnt = 0.
REQ-021 SHALL increment frame_cnt, modulo 2^16, on the cycle both counters wrap to 0.
REQ-022 SHALL drive {vga_r,vga_g,vga_b} = valid ? vga_data : 12'h000.
REQ-023 SHALL derive valid, hsync, vsync and frame_start from the raw terms, with alignment per REQ-027/028.

Reset
REQ-024 SHALL, while reset is high, hold h_cnt=0, v_cnt=0, frame_cnt=0, hsync=1, vsync=1, valid=0, frame_start=0 and rgb=0, and clear all delay registers.
REQ-025 SHALL, on the first rising clock edge after reset deasserts, advance h_cnt to 1; the cycle before that edge presents pixel (0,0).
REQ-026 SHALL, when reset asserts mid-frame, abandon the frame immediately (asynchronously); frame_cnt SHALL NOT increment for the abandoned frame.

Configuration
REQ-027 SHALL, when VGA_CTRL_SYNC_DELAY_EN is defined, register raw active, hsync, vsync and frame_start through one flop stage so they lag h_addr/v_addr by exactly one clock, matching a synchronous-read framebuffer (block RAM).
REQ-028 SHALL, when VGA_CTRL_SYNC_DELAY_EN is undefined, drive valid, hsync, vsync and frame_start combinationally from the counters in the same cycle as h_addr/v_addr, for an asynchronous-read framebuffer.

Verification
REQ-029 SHALL cover: reset release, macro off -> valid=1 at cycle 0 with h_addr=0, v_addr=0; valid falls after 640 cycles; hsync low for cycles 656..751 of line 0.
REQ-030 SHALL cover: full-frame run -> exactly 525 hsync pulses and 420000 clocks per frame; vsync low for lines 490..491 (1600 clocks); frame_cnt 0->1 at clock 420000.
REQ-031 SHALL cover: macro on, vga_data = address-derived pattern returned 1 clock late -> each visible rgb equals the pattern of the previous cycle's address; hsync falls at clock 657.
REQ-032 SHALL cover: vga_data=12'hFFF held constant -> rgb=0 outside the 640x480 window; 307200 valid pixels per frame.
REQ-033 SHALL cover: reset pulsed at h_cnt=300, v_cnt=200 -> outputs go to reset values without a clock; frame_cnt=0; after release, frame_start on the first visible pixel.
REQ-034 SHALL cover: 65536 frames with frame_cnt forced near wrap -> frame_cnt rolls from 16'hFFFF to 16'h0000, with frame_start still a single pulse.
